// File: rtl/seg_display_scanner.sv
// Converts a received byte to sign + three BCD digits (sequential double-dabble)
// and time-multiplexes them onto one registered seven-segment decoder.
module seg_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       signed_mode,
  input  logic       blank,
  output logic       busy,
  output logic [3:0] digit_code,
  output logic       digit_en,
  output logic [3:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0] CODE_MINUS = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Handshake: data_in/signed_mode are taken on a rising edge where
  // data_valid=1 and busy=0; strobes while busy=1 are dropped, never queued.

  state_e          state_q, state_d;
  logic [19:0]     sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [3:0]      hund_q, hund_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            dneg_q, dneg_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      code_q, code_d;
  logic            en_q, en_d;
  logic [1:0]      slot_q, slot_d;
  logic            sblank_q, sblank_d;
  logic [3:0]      an_q, an_d;

  logic            neg_in;
  logic [7:0]      mag;
  logic [19:0]     adj;
  logic            slot_blank;
  logic [3:0]      slot_code;

  // ---------------- conversion FSM ----------------
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    dneg_d  = dneg_q;
    neg_in  = signed_mode & data_in[7];
    mag     = neg_in ? (~data_in + 8'd1) : data_in;
    adj     = sr_q;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          neg_d   = neg_in;
          sr_d    = {12'b0, mag};
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = {adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // All four display fields change on the same edge so a scan never
        // shows a mix of old and new digits.
        hund_d  = sr_q[19:16];
        tens_d  = sr_q[15:12];
        ones_d  = sr_q[11:8];
        dneg_d  = neg_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // ---------------- scan / display pipeline ----------------
  always_comb begin
    presc_d    = presc_q + PW'(1);
    idx_d      = idx_q;
    slot_code  = 4'b0000;
    slot_blank = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    case (idx_q)
      2'd0: begin
        slot_code  = ones_q;
        slot_blank = 1'b0;
      end
      2'd1: begin
        slot_code  = tens_q;
        slot_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        slot_code  = hund_q;
        slot_blank = (hund_q == 4'd0);
      end
      default: begin
        slot_code  = dneg_q ? CODE_MINUS : 4'b0000;
        slot_blank = ~dneg_q;
      end
    endcase
    code_d   = slot_code;
    en_d     = 1'b1;
    // Anode select lags the code by one edge to match the decoder's register.
    slot_d   = idx_q;
    sblank_d = slot_blank | blank;
    an_d     = sblank_q ? 4'b1111 : ~(4'b0001 << slot_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hund_q   <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      dneg_q   <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      code_q   <= 4'b0000;
      en_q     <= 1'b0;
      slot_q   <= '0;
      sblank_q <= 1'b1;
      an_q     <= 4'b1111;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      dneg_q   <= dneg_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      en_q     <= en_d;
      slot_q   <= slot_d;
      sblank_q <= sblank_d;
      an_q     <= an_d;
    end
  end

  assign digit_code = code_q;
  assign digit_en   = en_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with SCAN_DIV=4: conversion latency,
// digit/anode pairing, leading-zero suppression, blanking and mid-conversion reset.
module tb_seg_display_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       signed_mode;
  logic       blank;
  logic       busy;
  logic [3:0] digit_code;
  logic       digit_en;
  logic [3:0] an;

  int tests_run = 0;
  int tests_failed = 0;

  seg_display_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .signed_mode (signed_mode),
    .blank       (blank),
    .busy        (busy),
    .digit_code  (digit_code),
    .digit_en    (digit_en),
    .an          (an)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns at the falling edge after the accepting edge.
  task automatic strobe(input logic [7:0] d, input logic sm);
    @(negedge clk);
    data_in     = d;
    signed_mode = sm;
    data_valid  = 1'b1;
    @(negedge clk);
    data_valid  = 1'b0;
  endtask

  // Counts sampled busy cycles after the accepting edge (bounded).
  task automatic wait_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    chk(tag, cnt, 9);
  endtask

  // Observes a full scan: each lit anode must pair with the code shown one
  // edge earlier for that slot; visible slot set must match vis.
  task automatic scan_check(input string tag,
                            input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3,
                            input logic [3:0] vis);
    logic [3:0] exp_c [4];
    logic [3:0] prev_code;
    logic [3:0] seen;
    logic [3:0] pat;
    logic       legal;
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
    seen = 4'b0000;
    @(negedge clk);
    prev_code = digit_code;
    repeat (20) begin
      @(negedge clk);
      legal = (an === 4'b1111);
      for (int s = 0; s < 4; s++) begin
        pat = ~(4'b0001 << s);
        if (an === pat) begin
          legal = 1'b1;
          if (!seen[s]) chk($sformatf("%s_code_slot%0d", tag, s), prev_code, exp_c[s]);
          seen[s] = 1'b1;
        end
      end
      chk({tag, "_an_legal"}, legal, 1'b1);
      prev_code = digit_code;
    end
    chk({tag, "_visible"}, seen, vis);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] seen_codes;
    int cnt;
    rst_n       = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    signed_mode = 1'b0;
    blank       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", digit_en, 1'b0);
    chk("rst_code", digit_code, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("en_after_rst", digit_en, 1'b1);
    scan_check("reset_zero", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);

    // -128 in signed mode
    strobe(8'h80, 1'b1);
    wait_busy("busy_80");
    scan_check("s80", 4'd8, 4'd2, 4'd1, 4'b1010, 4'b1111);

    // 255 unsigned, then 5 with leading zeros suppressed
    strobe(8'hFF, 1'b0);
    wait_busy("busy_ff");
    scan_check("uff", 4'd5, 4'd5, 4'd2, 4'd0, 4'b0111);
    strobe(8'h05, 1'b0);
    wait_busy("busy_05");
    scan_check("u05", 4'd5, 4'd0, 4'd0, 4'd0, 4'b0001);

    // 42, with 99 strobed on E4 while busy (must be dropped)
    strobe(8'd42, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 30) begin
      if (cnt == 3) begin
        data_in    = 8'd99;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("busy_42", cnt, 9);
    @(negedge clk);
    chk("no_queue_busy", busy, 1'b0);
    scan_check("u42", 4'd2, 4'd4, 4'd0, 4'd0, 4'b0011);

    // blank over a full scan while codes keep cycling
    strobe(8'h80, 1'b1);
    wait_busy("busy_80b");
    @(negedge clk);
    blank = 1'b1;
    repeat (2) @(negedge clk);
    seen_codes = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i % 4 == 0) chk($sformatf("blank_an_%0d", i), an, 4'b1111);
      else if (an !== 4'b1111) chk("blank_an_lit", an, 4'b1111);
      seen_codes[digit_code] = 1'b1;
    end
    chk("blank_codes_cycle",
        {seen_codes[10], seen_codes[8], seen_codes[2], seen_codes[1]}, 4'b1111);
    blank = 1'b0;
    scan_check("unblank", 4'd8, 4'd2, 4'd1, 4'b1010, 4'b1111);

    // reset right after E4 of a conversion
    strobe(8'd42, 1'b0);
    wait_busy("busy_42b");
    strobe(8'd77, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_an", an, 4'b1111);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_en", digit_en, 1'b0);
    chk("midrst_code", digit_code, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_en_back", digit_en, 1'b1);
    chk("midrst_idle", busy, 1'b0);
    scan_check("midrst_zero", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
